regfile_write_arbiter: RTL and testbench

- Round-robin arbiter that shares the single register-file write port between NUM_REQ requesters (ALU writeback, load unit, etc.).
- Each cycle it accepts at most one write request via valid/ready and registers the winning address/data.
- wr_addr drives the 4-to-16 write-enable decoder; wr_en gates the decoded enables into the register file.

---
 rtl/regfile_pkg.sv | 9 +
 rtl/regfile_write_arbiter_rr_pick.sv | 35 +++
 rtl/regfile_write_arbiter.sv | 93 +++++++++
 tb/tb_regfile_write_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Register-file geometry shared by the write arbiter, the decoder and the
// register file itself.
package regfile_pkg;

    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 2 ** ADDR_W;

endpackage

// File: rtl/regfile_write_arbiter_rr_pick.sv
// Combinational round-robin pick: rotate by ptr, take the first set bit,
// rotate back. Also intended for the future read-port arbiter.
module rr_pick #(
    parameter int N    = 4,
    parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    valid,
    input  logic [IDXW-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [IDXW-1:0] idx,
    output logic            any
);

    logic [IDXW:0] pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            // ptr < N and k < N, so one subtraction is a full modulo
            pos = {1'b0, ptr} + (IDXW + 1)'(k);
            if (pos >= (IDXW + 1)'(N)) begin
                pos = pos - (IDXW + 1)'(N);
            end
            if (!any && valid[pos[IDXW-1:0]]) begin
                any                   = 1'b1;
                grant[pos[IDXW-1:0]] = 1'b1;
                idx                   = pos[IDXW-1:0];
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register-file write port.
// Optional: REGARB_ZERO_REG_GUARD_EN suppresses wr_en for address 0.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = regfile_pkg::ADDR_W,
    parameter int DATA_W  = regfile_pkg::DATA_W,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      wr_stall,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    output logic [IDX_W-1:0]          grant_id
);

    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic [IDX_W-1:0]   grant_id_q, grant_id_d;

    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    rr_pick #(
        .N    (NUM_REQ),
        .IDXW (IDX_W)
    ) u_pick (
        .valid (req_valid),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign req_ready = (rst || wr_stall) ? '0 : pick_grant;

    always_comb begin
        ptr_d      = ptr_q;
        wr_en_d    = wr_en_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        grant_id_d = grant_id_q;
        // a stall freezes the pending beat until the register file takes it
        if (!wr_stall) begin
            wr_en_d = 1'b0;
            if (pick_any) begin
                wr_en_d    = 1'b1;
                wr_addr_d  = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                wr_data_d  = req_data[int'(pick_idx)*DATA_W +: DATA_W];
                grant_id_d = pick_idx;
                ptr_d      = (pick_idx == IDX_W'(NUM_REQ - 1))
                           ? '0 : pick_idx + IDX_W'(1);
`ifdef REGARB_ZERO_REG_GUARD_EN
                if (wr_addr_d == '0) begin
                    wr_en_d = 1'b0;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            grant_id_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            grant_id_q <= grant_id_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed and random checks of regfile_write_arbiter against a
// behavioural model of pending requests and a rotating priority.
module tb_regfile_write_arbiter;

    localparam int N  = 4;
    localparam int AW = 4;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            wr_stall;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic [1:0]      grant_id;

    always #5 clk = ~clk;

    regfile_write_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .DATA_W  (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_stall  (wr_stall),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .grant_id  (grant_id)
    );

    int checks   = 0;
    int failures = 0;

    bit            pv[N];
    logic [AW-1:0] pa[N];
    logic [DW-1:0] pd[N];

    int            m_ptr;
    bit            m_en;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [1:0]    m_gid;
    int            last_w;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick();
        if (rst || wr_stall) return -1;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (pv[j]) return j;
        end
        return -1;
    endfunction

    task automatic raise(input int i);
        pv[i] = 1'b1;
        pa[i] = AW'($urandom_range(0, 2 ** AW - 1));
        pd[i] = $urandom;
    endtask

    task automatic tick();
        int w;
        logic [N-1:0] er;
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = pv[i];
            req_addr[i*AW +: AW]  = pa[i];
            req_data[i*DW +: DW]  = pd[i];
        end
        w  = pick();
        er = '0;
        if (w >= 0) er[w] = 1'b1;
        #1;
        chk("req_ready", 64'(req_ready), 64'(er));
        @(posedge clk);
        if (rst) begin
            m_ptr  = 0;
            m_en   = 1'b0;
            m_addr = '0;
            m_data = '0;
            m_gid  = '0;
        end else if (!wr_stall) begin
            if (w >= 0) begin
                m_en   = 1'b1;
                m_addr = pa[w];
                m_data = pd[w];
                m_gid  = 2'(w);
`ifdef REGARB_ZERO_REG_GUARD_EN
                if (pa[w] == '0) m_en = 1'b0;
`endif
                m_ptr  = (w + 1) % N;
                pv[w]  = 1'b0;
            end else begin
                m_en = 1'b0;
            end
        end
        last_w = w;
        #1;
        chk("wr_en",    64'(wr_en),    64'(m_en));
        chk("wr_addr",  64'(wr_addr),  64'(m_addr));
        chk("wr_data",  64'(wr_data),  64'(m_data));
        chk("grant_id", 64'(grant_id), 64'(m_gid));
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        wr_stall  = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        m_ptr     = 0;
        m_en      = 1'b0;
        m_addr    = '0;
        m_data    = '0;
        m_gid     = '0;
        last_w    = -1;
        for (int i = 0; i < N; i++) begin
            pv[i] = 1'b0;
            pa[i] = '0;
            pd[i] = '0;
        end
        @(negedge clk);

        // reset cycles: no ready even with every requester valid
        tick();
        for (int i = 0; i < N; i++) raise(i);
        tick();
        for (int i = 0; i < N; i++) pv[i] = 1'b0;
        tick();
        rst = 1'b0;
        repeat (10) tick();

        // single requester 2
        pv[2] = 1'b1;
        pa[2] = 4'd5;
        pd[2] = 32'hDEADBEEF;
        tick();
        chk("single_en",   64'(wr_en),    64'd1);
        chk("single_addr", 64'(wr_addr),  64'd5);
        chk("single_data", 64'(wr_data),  64'hDEADBEEF);
        chk("single_gid",  64'(grant_id), 64'd2);
        // ptr is now 3: requester 0 and 3 valid, 3 must win
        raise(0);
        raise(3);
        tick();
        chk("ptr_after_2", 64'(grant_id), 64'd3);
        tick();

        rst = 1'b1;
        tick();
        rst = 1'b0;

        // all four valid: strict rotation, a beat every cycle
        for (int c = 0; c < 8; c++) begin
            if (c < 5) begin
                for (int i = 0; i < N; i++) if (!pv[i]) raise(i);
            end
            tick();
            chk("rr_seq", 64'(grant_id), 64'(c % N));
            chk("rr_en",  64'(wr_en),    64'd1);
        end

        // stall entered with a live beat, requesters 1 and 3 waiting
        raise(1);
        raise(3);
        wr_stall = 1'b1;
        repeat (3) tick();
        chk("stall_en_held", 64'(wr_en), 64'd1);
        wr_stall = 1'b0;
        tick();
        chk("post_stall_1", 64'(grant_id), 64'd1);
        tick();
        chk("post_stall_3", 64'(grant_id), 64'd3);

        // write to the zero register from requester 0
        pv[0] = 1'b1;
        pa[0] = '0;
        pd[0] = 32'h12345678;
        tick();
`ifdef REGARB_ZERO_REG_GUARD_EN
        chk("zero_en", 64'(wr_en), 64'd0);
`else
        chk("zero_en",   64'(wr_en),   64'd1);
        chk("zero_addr", 64'(wr_addr), 64'd0);
`endif
        raise(0);
        raise(1);
        tick();
        chk("zero_ptr", 64'(grant_id), 64'd1);
        tick();

        // reset right after an accept drops the beat
        raise(2);
        tick();
        rst = 1'b1;
        raise(1);
        raise(3);
        tick();
        chk("rst_drop", 64'(wr_en), 64'd0);
        rst = 1'b0;
        tick();
        chk("rst_first", 64'(grant_id), 64'd1);

        // random traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pv[i] && $urandom_range(0, 1) == 1) raise(i);
            end
            wr_stall = ($urandom_range(0, 4) == 0);
            rst      = ($urandom_range(0, 49) == 0);
            tick();
        end
        rst      = 1'b0;
        wr_stall = 1'b0;
        for (int c = 0; c < 8; c++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
